// File: rtl/bus_arbiter4_if.sv
// Bus-ownership handshake between the four bus sources and the round-robin
// arbiter that steers the shared 16-bit datapath mux.
interface bus_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_valid;

  // Arbiter side: samples requests, drives grant/select.
  modport master (
    input  req,
    output gnt,
    output sel,
    output bus_valid
  );

  // Source side: raises requests, observes grant/select.
  modport slave (
    output req,
    input  gnt,
    input  sel,
    input  bus_valid
  );
endinterface

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for the shared 4-input bus mux. Grants one source at a
// time, bounds ownership to MAX_HOLD cycles when others are waiting, and
// always leaves one idle cycle between owners so the mux never switches
// under an active grant.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner, no request seen; arbitrate every cycle
// OWN   | sel_q owns the bus; watch for release or preemption
// TURN  | single idle cycle after a release; arbitrate for the next owner
module bus_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic            clk,
  input logic            rst_n,
  bus_arbiter4_if.master bus
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [7:0] hold_cnt;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic       valid_q;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] scan_idx;
  logic [3:0] others_req;
  logic       owner_req;
  logic       release_now;

  // Rotating search starting one past the most recent owner; first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    scan_idx  = last;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last + 2'(k);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Owner's own request and whether anybody else is waiting behind it.
  always_comb begin
    owner_req   = bus.req[sel_q];
    others_req  = bus.req & ~(4'b0001 << sel_q);
    release_now = !owner_req || ((hold_cnt >= HOLD_LIM) && (others_req != 4'b0000));
  end

  // Sequencer: all outputs are registered here alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 2'd3;
      hold_cnt <= 8'd0;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, TURN: begin
          if (win_found) begin
            state    <= OWN;
            gnt_q    <= 4'b0001 << win_idx;
            sel_q    <= win_idx;
            valid_q  <= 1'b1;
            hold_cnt <= 8'd1;
          end else begin
            state   <= IDLE;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
          end
        end
        OWN: begin
          if (release_now) begin
            // sel_q is left alone so the mux keeps pointing at the old owner
            // through the turnaround cycle.
            state   <= TURN;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            last    <= sel_q;
          end else if (hold_cnt < HOLD_LIM) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          gnt_q   <= 4'b0000;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Drive the interface straight from the output registers.
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: the stimulus process drives req on the
// falling edge and queues the outputs a high-level ownership model predicts
// for the following rising edge; a separate monitor pops and compares.
module tb_bus_arbiter4;

  localparam int H = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bus_arbiter4_if bus ();

  bus_arbiter4 #(.MAX_HOLD(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns the bus, for how long, who was last.
  int m_owner;
  int m_last;
  int m_held;
  int m_sel;

  // Grant history recorded by the monitor for the round-robin scenario.
  logic rec_en = 1'b0;
  int   grant_log[$];
  int   len_log[$];
  int   run_len = 0;
  logic prev_valid = 1'b0;

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_sel   = 0;
  endfunction

  // One rising edge seen from the bus's point of view.
  function automatic void model_step(logic [3:0] r);
    int others;
    int idx;
    if (m_owner >= 0) begin
      others = int'(r) & ~(1 << m_owner);
      if (!r[m_owner] || (m_held >= H && others != 0)) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_sel   = idx;
          m_held  = 1;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.valid = (m_owner >= 0);
    return e;
  endfunction

  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    bus.req = r;
    model_step(r);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) cycle(r);
  endtask

  // Assert reset away from any edge, confirm outputs clear at once, then
  // release on a falling edge with req idle.
  task automatic apply_reset(input logic [3:0] r_hold, input string tag);
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    bus.req = r_hold;
    model_reset();
    #1;
    check({tag, "_gnt"},   bus.gnt,       8'd0);
    check({tag, "_sel"},   bus.sel,       8'd0);
    check({tag, "_valid"}, bus.bus_valid, 8'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_gnt"},   bus.gnt,       8'd0);
      check({tag, "_hold_valid"}, bus.bus_valid, 8'd0);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    rst_n   = 1'b1;
    model_step(4'b0000);
    exp_q.push_back(model_out());
  endtask

  // Monitor: compares the DUT against the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rec_en) begin
        if (bus.bus_valid && !prev_valid) begin
          grant_log.push_back(int'(bus.sel));
          run_len = 0;
        end
        if (bus.bus_valid) run_len++;
        if (!bus.bus_valid && prev_valid) len_log.push_back(run_len);
      end
      prev_valid = bus.bus_valid;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",       bus.gnt,       e.gnt);
        check("sel",       bus.sel,       e.sel);
        check("bus_valid", bus.bus_valid, e.valid);
      end
    end
  end

  initial begin
    int rr_exp[5];
    logic [3:0] r;
    rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 2; rr_exp[3] = 3; rr_exp[4] = 0;
    bus.req = 4'b1111;
    model_reset();

    // Reset held with every source requesting.
    apply_reset(4'b1111, "rst_req");

    // Round robin with full contention.
    rec_en = 1'b1;
    run(4'b1111, 26);
    rec_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rr_owner", (i < grant_log.size()) ? 8'(grant_log[i]) : 8'hff, 8'(rr_exp[i]));
      check("rr_len",   (i < len_log.size())   ? 8'(len_log[i])   : 8'hff, 8'(H));
    end
    run(4'b0000, 3);

    // Single requester, then release and idle with sel held.
    run(4'b0100, 5);
    run(4'b0000, 4);

    // Uncontended ownership, then late contention after saturation.
    run(4'b0010, 20);
    run(4'b0000, 3);
    run(4'b0010, 12);
    run(4'b1010, 8);
    run(4'b0000, 3);

    // Priority rotation after preemption of source 2.
    run(4'b0100, 3);
    run(4'b0101, 16);
    run(4'b0000, 3);

    // Reset in the middle of a grant.
    run(4'b1111, 3);
    apply_reset(4'b1111, "rst_mid");

    // Randomised requests with sticky bits.
    r = 4'b0000;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(4) == 0) r[b] = ~r[b];
      if ($urandom_range(39) == 0) r = 4'b0000;
      cycle(r);
      if (n == 400) apply_reset(4'b1111, "rst_rand");
    end

    @(posedge clk);
    #3;
    check("drain", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Round-robin arbiter and sequencer for the shared 16-bit, 4-input datapath bus multiplexer.
- Takes one request line from each of four bus sources and grants the bus to exactly one of them.
- Drives the mux's 2-bit select with the owner's index.
- Bounds ownership with a hold limit so no source can starve the others.
- Inserts one turnaround cycle between owners so the bus never switches sources while a grant is active.

## Interface
- MAX_HOLD, default 8: cycles an owner may keep the bus while any other request is pending. Legal range 1..255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  per-source request; bit i = source i (mux input a=0, b=1, c=2, d=3). Held high for as long as the source wants the bus.
- gnt  output  4  one-hot grant, all-zero when no owner. Registered.
- sel  output  2  mux select, equal to the index of the current or most recent owner. Registered.
- bus_valid  output  1  high exactly when gnt is non-zero. Registered.

## Operation
- State machine: IDLE, OWN, TURN.
- Internal registers: last[1:0] (most recent owner), hold_cnt[7:0].
- Arbitration (evaluated in IDLE and TURN):
  - Search req starting at index last+1, wrapping modulo 4; the first set bit wins.
  - last resets to 3, so source 0 has first priority after reset.
- IDLE:
  - If req != 0: go to OWN. Set gnt to the winner (one-hot), sel to the winner, bus_valid=1, hold_cnt=1.
  - Otherwise stay in IDLE. gnt=0, bus_valid=0, sel holds its value.
- OWN (owner = sel):
  - If req[sel]=0: release.
  - Else if hold_cnt >= MAX_HOLD and (req with bit sel masked) != 0: release (preemption).
  - Otherwise stay in OWN. hold_cnt increments, saturating at MAX_HOLD.
  - Release: go to TURN. gnt=0, bus_valid=0, last=sel; sel unchanged.
- TURN (exactly one cycle, bus idle):
  - Arbitrate the current req. If there is a winner, go to OWN as from IDLE; else go to IDLE.
  - A preempted owner that still requests competes normally. It has lowest priority because last equals its index.
- Invariants:
  - gnt has at most one bit set.
  - bus_valid == |gnt.
  - When gnt != 0, gnt == (1 << sel).
  - sel never changes while bus_valid=1.
  - At least one bus_valid=0 cycle separates two consecutive grants.
- Requests from non-owners never affect the current owner, except through the preemption rule.

## Timing
- Reset: asynchronous on rst_n low.
  - gnt=0, sel=0, bus_valid=0, state=IDLE, last=3, hold_cnt=0.
  - Takes effect immediately, including mid-grant.
  - First arbitration happens at the first rising edge with rst_n high.
- Grant latency from IDLE: req sampled at edge N → gnt/sel/bus_valid valid after edge N.
- Release latency: req[owner] low before edge N → gnt=0 after edge N (TURN) → next grant earliest after edge N+1.
- Preemption: hold_cnt reaches MAX_HOLD with contention → gnt drops at that edge. The owner holds the bus for exactly MAX_HOLD cycles of bus_valid=1.
- Contention arriving late: owner already saturated at MAX_HOLD, another req rises before edge N → release at edge N.
- Simultaneous owner drop and new request: handled as a plain release; the new request is arbitrated in TURN.
- All-four contention with MAX_HOLD=H: each grant lasts H cycles, and the grant period repeats every 4·(H+1) cycles.

## Test plan
- Reset: hold rst_n low with req=4'b1111 → gnt=0, sel=0, bus_valid=0. Assert rst_n low mid-grant → all outputs clear before the next edge.
- Single requester: req=4'b0100 from cycle 0 → after edge 1 gnt=4'b0100, sel=2, bus_valid=1. Drop req → gnt=0 after the next edge, then IDLE with sel=2 held.
- Round robin, MAX_HOLD=4, req=4'b1111 from reset:
  - Grants in order 0,1,2,3,0, each 4 cycles, with one bus_valid=0 cycle between grants.
  - sel sequence 0,1,2,3,0.
- No contention: req[1] high for 20 cycles, MAX_HOLD=8 → gnt=4'b0010 for all 20 cycles with no gap.
- Late contention: in the no-contention case, raise req[3] at cycle 12 → gnt[1] drops at the next edge, one TURN cycle, then gnt=4'b1000, sel=3.
- Priority rotation: owner 2 releases while req=4'b0101 → next grant goes to source 0, not 2. Then, with req=4'b0101 held, grant to 2 after source 0 releases.
